// File: rtl/ram_sdp_be_pkg.sv
// Shared types, constants and helpers for the ram_sdp_be memory block.
package ram_pkg;

   // Clear-engine states.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   // Read-during-write policies.
   localparam int READ_FIRST  = 0;
   localparam int WRITE_FIRST = 1;

   // Widest word the merge helper handles; callers zero-extend into it.
   localparam int MERGE_MAX_W  = 512;
   localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

   // Byte-lane merge: enabled lanes take new_w, the rest keep old_w.
   function automatic logic [MERGE_MAX_W-1:0] byte_merge(
      input logic [MERGE_MAX_W-1:0]  old_w,
      input logic [MERGE_MAX_W-1:0]  new_w,
      input logic [MERGE_MAX_BE-1:0] be
   );
      logic [MERGE_MAX_W-1:0] res;
      res = old_w;
      for (int i = 0; i < MERGE_MAX_BE; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_w[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_w[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ram_sdp_be_if.sv
// Request/response bundle of the ram_sdp_be memory.
interface ram_sdp_be_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic                  wr_en;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic [DATA_W/8-1:0]   wr_be;
   logic                  rd_en;
   logic [ADDR_W-1:0]     rd_addr;
   logic                  clr_req;
   logic [DATA_W-1:0]     rd_data;
   logic                  rd_valid;
   logic                  rd_err;
   logic                  wr_err;
   logic                  busy;

   modport master (
      output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_req,
      input  rd_data, rd_valid, rd_err, wr_err, busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_req,
      output rd_data, rd_valid, rd_err, wr_err, busy
   );
endinterface

// File: rtl/ram_sdp_be_init_ctrl.sv
// Clear engine: IDLE/CLEAR FSM, clear address counter and the write-port mux
// that hands the array either the user write or the zeroing write.
module ram_init_ctrl
   import ram_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int DEPTH         = 256,
   parameter int ADDR_W        = $clog2(DEPTH),
   parameter int INIT_ON_RESET = 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                clr_req_i,
   input  logic                wr_en_i,
   input  logic [ADDR_W-1:0]   wr_addr_i,
   input  logic [DATA_W-1:0]   wr_data_i,
   input  logic [DATA_W/8-1:0] wr_be_i,
   output logic                busy_o,
   output logic                arr_we_o,
   output logic [ADDR_W-1:0]   arr_addr_o,
   output logic [DATA_W-1:0]   arr_data_o,
   output logic [DATA_W/8-1:0] arr_be_o
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic              INIT_RST  = (INIT_ON_RESET != 0) ? 1'b1 : 1'b0;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              init_q, init_d;   // pending power-on clear

   // State, counter and pending-init registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         init_q  <= INIT_RST;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         init_q  <= init_d;
      end
   end

   // Next-state logic: start on pending init or clr_req, sweep 0..DEPTH-1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      init_d  = init_q;
      case (state_q)
         IDLE: begin
            if (init_q) begin
               state_d = CLEAR;
               init_d  = 1'b0;
            end else if (clr_req_i) begin
               state_d = CLEAR;
            end else begin
               state_d = IDLE;
            end
         end
         CLEAR: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy_o = (state_q == CLEAR);

   // Array write port: zeroing write while clearing, otherwise the user write.
   always_comb begin
      arr_we_o   = 1'b0;
      arr_addr_o = wr_addr_i;
      arr_data_o = wr_data_i;
      arr_be_o   = wr_be_i;
      if (state_q == CLEAR) begin
         arr_we_o   = 1'b1;
         arr_addr_o = cnt_q;
         arr_data_o = '0;
         arr_be_o   = '1;
      end else begin
         arr_we_o = wr_en_i;
      end
   end

endmodule

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write policy, range checking and a clear engine.
module ram_sdp_be
   import ram_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 256,
   parameter int ADDR_W         = $clog2(DEPTH),
   parameter int RD_LATENCY     = 1,
   parameter int COLLISION_MODE = READ_FIRST,
   parameter int INIT_ON_RESET  = 1
) (
   input logic         clk,
   input logic         rstn,
   ram_sdp_be_if.slave bus
);
   localparam int              BE_W    = DATA_W / 8;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   if ((DATA_W % 8) != 0) begin : g_bad_data_w
      $error("ram_sdp_be: DATA_W must be a multiple of 8");
   end
   if (DATA_W > MERGE_MAX_W) begin : g_wide_data_w
      $error("ram_sdp_be: DATA_W exceeds byte_merge width");
   end
   if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
      $error("ram_sdp_be: RD_LATENCY must be 1 or 2");
   end

   logic [DATA_W-1:0]      mem_q [DEPTH];
   logic                   busy_s, arr_we_s;
   logic [ADDR_W-1:0]      arr_addr_s;
   logic [DATA_W-1:0]      arr_data_s;
   logic [BE_W-1:0]        arr_be_s;
   logic                   wr_in_range_s, rd_in_range_s, wr_ok_s, rd_fire_s, coll_s;
   logic [DATA_W-1:0]      old_word_s, rd_word_s;
   logic [MERGE_MAX_W-1:0] merge_full_s;
   logic                   s1_valid_q, s1_err_q, wr_err_q;
   logic [DATA_W-1:0]      s1_data_q;

   assign wr_in_range_s = ({1'b0, bus.wr_addr} < DEPTH_X);
   assign rd_in_range_s = ({1'b0, bus.rd_addr} < DEPTH_X);
   assign wr_ok_s       = bus.wr_en & wr_in_range_s;
   assign rd_fire_s     = bus.rd_en & ~busy_s;
   assign coll_s        = wr_ok_s & ~busy_s & (bus.wr_addr == bus.rd_addr);

   ram_init_ctrl #(
      .DATA_W        (DATA_W),
      .DEPTH         (DEPTH),
      .ADDR_W        (ADDR_W),
      .INIT_ON_RESET (INIT_ON_RESET)
   ) u_init_ctrl (
      .clk        (clk),
      .rstn       (rstn),
      .clr_req_i  (bus.clr_req),
      .wr_en_i    (wr_ok_s),
      .wr_addr_i  (bus.wr_addr),
      .wr_data_i  (bus.wr_data),
      .wr_be_i    (bus.wr_be),
      .busy_o     (busy_s),
      .arr_we_o   (arr_we_s),
      .arr_addr_o (arr_addr_s),
      .arr_data_o (arr_data_s),
      .arr_be_o   (arr_be_s)
   );

   // Byte-lane writes into the array; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (arr_we_s) begin
         for (int i = 0; i < BE_W; i++) begin
            if (arr_be_s[i]) begin
               mem_q[arr_addr_s][8*i +: 8] <= arr_data_s[8*i +: 8];
            end
         end
      end
   end

   // Read word selection: zero when out of range, forwarded merge on a
   // same-address write when the write-first policy is selected.
   always_comb begin
      old_word_s   = '0;
      rd_word_s    = '0;
      if (rd_in_range_s) begin
         old_word_s = mem_q[bus.rd_addr];
      end else begin
         old_word_s = '0;
      end
      merge_full_s = byte_merge(MERGE_MAX_W'(old_word_s), MERGE_MAX_W'(bus.wr_data),
                                MERGE_MAX_BE'(bus.wr_be));
      if (!rd_in_range_s) begin
         rd_word_s = '0;
      end else if ((COLLISION_MODE == WRITE_FIRST) && coll_s) begin
         rd_word_s = merge_full_s[DATA_W-1:0];
      end else begin
         rd_word_s = old_word_s;
      end
   end

   if (DATA_W < MERGE_MAX_W) begin : g_merge_pad
      logic unused_merge_s;
      assign unused_merge_s = ^merge_full_s[MERGE_MAX_W-1:DATA_W];
   end

   // First read stage and the write-error strobe; data holds between reads.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q <= 1'b0;
         s1_err_q   <= 1'b0;
         s1_data_q  <= '0;
         wr_err_q   <= 1'b0;
      end else begin
         s1_valid_q <= rd_fire_s;
         s1_err_q   <= rd_fire_s & ~rd_in_range_s;
         wr_err_q   <= bus.wr_en & ~busy_s & ~wr_in_range_s;
         if (rd_fire_s) begin
            s1_data_q <= rd_word_s;
         end
      end
   end

   if (RD_LATENCY == 2) begin : g_lat2
      logic              s2_valid_q, s2_err_q;
      logic [DATA_W-1:0] s2_data_q;

      // Extra output register stage for the two-cycle read latency.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            s2_valid_q <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_data_q  <= '0;
         end else begin
            s2_valid_q <= s1_valid_q;
            s2_err_q   <= s1_err_q;
            if (s1_valid_q) begin
               s2_data_q <= s1_data_q;
            end
         end
      end

      assign bus.rd_valid = s2_valid_q;
      assign bus.rd_err   = s2_err_q;
      assign bus.rd_data  = s2_data_q;
   end else begin : g_lat1
      assign bus.rd_valid = s1_valid_q;
      assign bus.rd_err   = s1_err_q;
      assign bus.rd_data  = s1_data_q;
   end

   assign bus.wr_err = wr_err_q;
   assign bus.busy   = busy_s;

endmodule

// File: tb/tb_ram_sdp_be.sv
// Self-checking bench for ram_sdp_be: dut_a is 256x32 read-first latency 1,
// dut_b is 200x32 write-first latency 2. Expected reads go into per-DUT
// queues with the loop index at which rd_valid must appear.
module tb_ram_sdp_be;
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   ram_sdp_be_if #(.DATA_W(32), .ADDR_W(8)) ifa ();
   ram_sdp_be_if #(.DATA_W(32), .ADDR_W(8)) ifb ();

   ram_sdp_be #(.DATA_W(32), .DEPTH(256), .ADDR_W(8), .RD_LATENCY(1),
                .COLLISION_MODE(0), .INIT_ON_RESET(1))
      dut_a (.clk(clk), .rstn(rstn), .bus(ifa));

   ram_sdp_be #(.DATA_W(32), .DEPTH(200), .ADDR_W(8), .RD_LATENCY(2),
                .COLLISION_MODE(1), .INIT_ON_RESET(1))
      dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t exp_a[$];
   exp_t exp_b[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic drive_a(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                          input logic [3:0] be, input logic re, input logic [7:0] ra);
      ifa.wr_en = we; ifa.wr_addr = wa; ifa.wr_data = wd; ifa.wr_be = be;
      ifa.rd_en = re; ifa.rd_addr = ra;
   endtask

   task automatic drive_b(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                          input logic [3:0] be, input logic re, input logic [7:0] ra);
      ifb.wr_en = we; ifb.wr_addr = wa; ifb.wr_data = wd; ifb.wr_be = be;
      ifb.rd_en = re; ifb.rd_addr = ra;
   endtask

   task automatic test_reset();
      int   na, nb;
      exp_t e;
      rstn = 1'b0;
      drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0); ifa.clr_req = 1'b0;
      drive_b(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0); ifb.clr_req = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ifa.rd_data, ifa.rd_valid, ifa.rd_err, ifa.wr_err, ifa.busy} !== 36'd0) begin
         failures++;
         $display("FAIL reset_a_outputs got data=%h v=%b re=%b we=%b busy=%b exp all zero",
                  ifa.rd_data, ifa.rd_valid, ifa.rd_err, ifa.wr_err, ifa.busy);
      end
      checks++;
      if ({ifb.rd_data, ifb.rd_valid, ifb.rd_err, ifb.wr_err, ifb.busy} !== 36'd0) begin
         failures++;
         $display("FAIL reset_b_outputs got data=%h v=%b re=%b we=%b busy=%b exp all zero",
                  ifb.rd_data, ifb.rd_valid, ifb.rd_err, ifb.wr_err, ifb.busy);
      end
      rstn = 1'b1;
      na = 0; nb = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (ifa.busy !== 1'b1) break;
         na++;
         if (ifb.busy === 1'b1) nb++;
      end
      checks++;
      if (na != 256) begin
         failures++; $display("FAIL reset_busy_a got=%0d exp=256", na);
      end
      checks++;
      if (nb != 200) begin
         failures++; $display("FAIL reset_busy_b got=%0d exp=200", nb);
      end
      for (int c = 0; c < 4; c++) begin
         if (ifa.rd_valid === 1'b1) begin
            checks++;
            if (exp_a.size() == 0) begin
               failures++; $display("FAIL reset_a_unexpected_valid got=1 exp=0 cyc=%0d", c);
            end else begin
               e = exp_a.pop_front();
               if (ifa.rd_data !== e.data || ifa.rd_err !== e.err || c != e.cyc) begin
                  failures++;
                  $display("FAIL reset_a_read got data=%h err=%b cyc=%0d exp data=%h err=%b cyc=%0d",
                           ifa.rd_data, ifa.rd_err, c, e.data, e.err, e.cyc);
               end
            end
         end
         if (c == 0) begin
            drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd10);
            exp_a.push_back('{32'h0, 1'b0, c + 1});
         end else begin
            drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
         end
         @(negedge clk);
      end
      checks++;
      if (exp_a.size() != 0) begin
         failures++; $display("FAIL reset_a_missing_valid got=%0d pending exp=0", exp_a.size());
         exp_a.delete();
      end
   endtask

   task automatic test_byte_merge();
      exp_t e;
      for (int c = 0; c < 6; c++) begin
         if (ifa.rd_valid === 1'b1) begin
            checks++;
            if (exp_a.size() == 0) begin
               failures++; $display("FAIL merge_a_unexpected_valid got=1 exp=0 cyc=%0d", c);
            end else begin
               e = exp_a.pop_front();
               if (ifa.rd_data !== e.data || ifa.rd_err !== e.err || c != e.cyc) begin
                  failures++;
                  $display("FAIL merge_a_read got data=%h err=%b cyc=%0d exp data=%h err=%b cyc=%0d",
                           ifa.rd_data, ifa.rd_err, c, e.data, e.err, e.cyc);
               end
            end
         end
         case (c)
            0: drive_a(1'b1, 8'd10, 32'h0000_00FF, 4'hF, 1'b0, 8'd0);
            1: drive_a(1'b1, 8'd10, 32'hAABB_CCDD, 4'b1010, 1'b0, 8'd0);
            2: begin
               drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd10);
               exp_a.push_back('{32'hAA00_CCFF, 1'b0, c + 1});
            end
            default: drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
         endcase
         @(negedge clk);
      end
      checks++;
      if (exp_a.size() != 0) begin
         failures++; $display("FAIL merge_a_missing_valid got=%0d pending exp=0", exp_a.size());
         exp_a.delete();
      end
   endtask

   task automatic test_collision();
      exp_t e;
      for (int c = 0; c < 8; c++) begin
         if (ifa.rd_valid === 1'b1) begin
            checks++;
            if (exp_a.size() == 0) begin
               failures++; $display("FAIL coll_a_unexpected_valid got=1 exp=0 cyc=%0d", c);
            end else begin
               e = exp_a.pop_front();
               if (ifa.rd_data !== e.data || ifa.rd_err !== e.err || c != e.cyc) begin
                  failures++;
                  $display("FAIL coll_a_read got data=%h err=%b cyc=%0d exp data=%h err=%b cyc=%0d",
                           ifa.rd_data, ifa.rd_err, c, e.data, e.err, e.cyc);
               end
            end
         end
         if (ifb.rd_valid === 1'b1) begin
            checks++;
            if (exp_b.size() == 0) begin
               failures++; $display("FAIL coll_b_unexpected_valid got=1 exp=0 cyc=%0d", c);
            end else begin
               e = exp_b.pop_front();
               if (ifb.rd_data !== e.data || ifb.rd_err !== e.err || c != e.cyc) begin
                  failures++;
                  $display("FAIL coll_b_read got data=%h err=%b cyc=%0d exp data=%h err=%b cyc=%0d",
                           ifb.rd_data, ifb.rd_err, c, e.data, e.err, e.cyc);
               end
            end
         end
         case (c)
            0: begin
               drive_a(1'b1, 8'd5, 32'h1234_5678, 4'hF, 1'b1, 8'd5);
               exp_a.push_back('{32'h0, 1'b0, c + 1});
               drive_b(1'b1, 8'd5, 32'h1234_5678, 4'hF, 1'b1, 8'd5);
               exp_b.push_back('{32'h1234_5678, 1'b0, c + 2});
            end
            1: begin
               drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd5);
               exp_a.push_back('{32'h1234_5678, 1'b0, c + 1});
               drive_b(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd5);
               exp_b.push_back('{32'h1234_5678, 1'b0, c + 2});
            end
            2: begin
               drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
               drive_b(1'b1, 8'd5, 32'hAABB_CCDD, 4'b0101, 1'b1, 8'd5);
               exp_b.push_back('{32'h12BB_56DD, 1'b0, c + 2});
            end
            default: begin
               drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
               drive_b(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
            end
         endcase
         @(negedge clk);
      end
      checks++;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         failures++;
         $display("FAIL coll_missing_valid got a=%0d b=%0d pending exp=0", exp_a.size(), exp_b.size());
         exp_a.delete(); exp_b.delete();
      end
   endtask

   task automatic test_out_of_range();
      exp_t e;
      for (int c = 0; c < 8; c++) begin
         if (ifb.rd_valid === 1'b1) begin
            checks++;
            if (exp_b.size() == 0) begin
               failures++; $display("FAIL oor_b_unexpected_valid got=1 exp=0 cyc=%0d", c);
            end else begin
               e = exp_b.pop_front();
               if (ifb.rd_data !== e.data || ifb.rd_err !== e.err || c != e.cyc) begin
                  failures++;
                  $display("FAIL oor_b_read got data=%h err=%b cyc=%0d exp data=%h err=%b cyc=%0d",
                           ifb.rd_data, ifb.rd_err, c, e.data, e.err, e.cyc);
               end
            end
         end
         if (c >= 1 && c <= 3) begin
            checks++;
            if (ifb.wr_err !== (c == 1)) begin
               failures++;
               $display("FAIL oor_wr_err cyc=%0d got=%b exp=%b", c, ifb.wr_err, (c == 1));
            end
         end
         case (c)
            0: drive_b(1'b1, 8'd200, 32'hDEAD_BEEF, 4'hF, 1'b0, 8'd0);
            1: begin
               drive_b(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd0);
               exp_b.push_back('{32'h0, 1'b0, c + 2});
            end
            2: begin
               drive_b(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd255);
               exp_b.push_back('{32'h0, 1'b1, c + 2});
            end
            3: begin
               drive_b(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd200);
               exp_b.push_back('{32'h0, 1'b1, c + 2});
            end
            default: drive_b(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
         endcase
         @(negedge clk);
      end
      checks++;
      if (exp_b.size() != 0) begin
         failures++; $display("FAIL oor_b_missing_valid got=%0d pending exp=0", exp_b.size());
         exp_b.delete();
      end
   endtask

   task automatic test_clear_busy();
      int   n, bad;
      exp_t e;
      for (int c = 0; c < 5; c++) begin
         if (c < 4) drive_a(1'b1, 8'(c), 32'(c + 1), 4'hF, 1'b0, 8'd0);
         else begin
            drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
            ifa.clr_req = 1'b1;
         end
         @(negedge clk);
      end
      ifa.clr_req = 1'b0;
      n = 0; bad = 0;
      for (int c = 0; c < 400; c++) begin
         if (ifa.busy !== 1'b1) break;
         n++;
         if (ifa.rd_valid !== 1'b0 || ifa.rd_err !== 1'b0 || ifa.wr_err !== 1'b0) bad++;
         drive_a(1'b1, 8'(c), 32'hFFFF_FFFF, 4'hF, 1'b1, 8'(c));
         ifa.clr_req = (c == 50);
         @(negedge clk);
      end
      drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
      ifa.clr_req = 1'b0;
      checks++;
      if (n != 256) begin
         failures++; $display("FAIL clear_busy_len got=%0d exp=256", n);
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL clear_strobes_while_busy got=%0d exp=0", bad);
      end
      for (int c = 0; c < 7; c++) begin
         if (ifa.rd_valid === 1'b1) begin
            checks++;
            if (exp_a.size() == 0) begin
               failures++; $display("FAIL clear_a_unexpected_valid got=1 exp=0 cyc=%0d", c);
            end else begin
               e = exp_a.pop_front();
               if (ifa.rd_data !== e.data || ifa.rd_err !== e.err || c != e.cyc) begin
                  failures++;
                  $display("FAIL clear_a_read got data=%h err=%b cyc=%0d exp data=%h err=%b cyc=%0d",
                           ifa.rd_data, ifa.rd_err, c, e.data, e.err, e.cyc);
               end
            end
         end
         if (c < 4) begin
            drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'(c));
            exp_a.push_back('{32'h0, 1'b0, c + 1});
         end else begin
            drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
         end
         @(negedge clk);
      end
      checks++;
      if (exp_a.size() != 0) begin
         failures++; $display("FAIL clear_a_missing_valid got=%0d pending exp=0", exp_a.size());
         exp_a.delete();
      end
   endtask

   task automatic test_reset_mid_clear();
      int   na, nb;
      exp_t e;
      for (int c = 0; c < 5; c++) begin
         if (ifa.rd_valid === 1'b1) begin
            checks++;
            if (exp_a.size() == 0) begin
               failures++; $display("FAIL hold_a_unexpected_valid got=1 exp=0 cyc=%0d", c);
            end else begin
               e = exp_a.pop_front();
               if (ifa.rd_data !== e.data || ifa.rd_err !== e.err || c != e.cyc) begin
                  failures++;
                  $display("FAIL hold_a_read got data=%h err=%b cyc=%0d exp data=%h err=%b cyc=%0d",
                           ifa.rd_data, ifa.rd_err, c, e.data, e.err, e.cyc);
               end
            end
         end
         if (c == 3) begin
            checks++;
            if (ifa.rd_valid !== 1'b0 || ifa.rd_data !== 32'hCAFE_F00D) begin
               failures++;
               $display("FAIL hold_rd_data got v=%b data=%h exp v=0 data=cafef00d",
                        ifa.rd_valid, ifa.rd_data);
            end
         end
         case (c)
            0: drive_a(1'b1, 8'd7, 32'hCAFE_F00D, 4'hF, 1'b0, 8'd0);
            1: begin
               drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd7);
               exp_a.push_back('{32'hCAFE_F00D, 1'b0, c + 1});
            end
            4: begin
               drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
               ifa.clr_req = 1'b1;
            end
            default: drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
         endcase
         @(negedge clk);
      end
      ifa.clr_req = 1'b0;
      repeat (99) @(negedge clk);
      checks++;
      if (ifa.busy !== 1'b1) begin
         failures++; $display("FAIL midclear_busy got=%b exp=1", ifa.busy);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if ({ifa.rd_data, ifa.rd_valid, ifa.rd_err, ifa.wr_err, ifa.busy} !== 36'd0) begin
         failures++;
         $display("FAIL midclear_reset_outputs got data=%h v=%b re=%b we=%b busy=%b exp all zero",
                  ifa.rd_data, ifa.rd_valid, ifa.rd_err, ifa.wr_err, ifa.busy);
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      na = 0; nb = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (ifa.busy !== 1'b1) break;
         na++;
         if (ifb.busy === 1'b1) nb++;
      end
      checks++;
      if (na != 256 || nb != 200) begin
         failures++; $display("FAIL restart_busy got a=%0d b=%0d exp a=256 b=200", na, nb);
      end
      for (int c = 0; c < 12; c++) begin
         if (ifa.rd_valid === 1'b1) begin
            checks++;
            if (exp_a.size() == 0) begin
               failures++; $display("FAIL b2b_a_unexpected_valid got=1 exp=0 cyc=%0d", c);
            end else begin
               e = exp_a.pop_front();
               if (ifa.rd_data !== e.data || ifa.rd_err !== e.err || c != e.cyc) begin
                  failures++;
                  $display("FAIL b2b_a_read got data=%h err=%b cyc=%0d exp data=%h err=%b cyc=%0d",
                           ifa.rd_data, ifa.rd_err, c, e.data, e.err, e.cyc);
               end
            end
         end
         if (ifb.rd_valid === 1'b1) begin
            checks++;
            if (exp_b.size() == 0) begin
               failures++; $display("FAIL b2b_b_unexpected_valid got=1 exp=0 cyc=%0d", c);
            end else begin
               e = exp_b.pop_front();
               if (ifb.rd_data !== e.data || ifb.rd_err !== e.err || c != e.cyc) begin
                  failures++;
                  $display("FAIL b2b_b_read got data=%h err=%b cyc=%0d exp data=%h err=%b cyc=%0d",
                           ifb.rd_data, ifb.rd_err, c, e.data, e.err, e.cyc);
               end
            end
         end
         if (c < 3) begin
            drive_a(1'b1, 8'(c + 1), 32'(32'h1111_1111 * (c + 1)), 4'hF, 1'b0, 8'd0);
            drive_b(1'b1, 8'(c + 1), 32'(32'h1111_1111 * (c + 1)), 4'hF, 1'b0, 8'd0);
         end else if (c < 6) begin
            drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'(c - 2));
            drive_b(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'(c - 2));
            exp_a.push_back('{32'(32'h1111_1111 * (c - 2)), 1'b0, c + 1});
            exp_b.push_back('{32'(32'h1111_1111 * (c - 2)), 1'b0, c + 2});
         end else begin
            drive_a(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
            drive_b(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
         end
         @(negedge clk);
      end
      checks++;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         failures++;
         $display("FAIL b2b_missing_valid got a=%0d b=%0d pending exp=0", exp_a.size(), exp_b.size());
         exp_a.delete(); exp_b.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_byte_merge();
      test_collision();
      test_out_of_range();
      test_clear_busy();
      test_reset_mid_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
Parametrised simple dual-port synchronous RAM. It is the successor to the single-width 32-bit RAM block, with one independent read port and one write port on the same clock. Adds per-byte write enables, configurable read latency, defined read-during-write behaviour, out-of-range detection, and a hardware clear engine that zeroes the array after reset or on request. Used as the general scratch/buffer memory for datapath blocks.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
DEPTH, 256, number of words; need not be a power of two.
ADDR_W, $clog2(DEPTH), address width.
RD_LATENCY, 1, read latency in cycles; legal values are 1 and 2.
COLLISION_MODE, 0, 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data).
INIT_ON_RESET, 1, 1 = run the clear sequence after reset release.

Ports:
clk  in  1  rising-edge clock
rstn  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte-lane write enables; bit i covers wr_data[8i+7:8i]
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  read data
rd_valid  out  1  one-cycle strobe: rd_data is valid
rd_err  out  1  read address was out of range; aligned with rd_valid
wr_err  out  1  one-cycle pulse the cycle after an out-of-range write was dropped
clr_req  in  1  pulse; request a full clear
busy  out  1  clear in progress; all requests are ignored

Behaviour:
- Reset (rstn=0, asynchronous): rd_data=0, rd_valid=0, rd_err=0, wr_err=0, FSM goes to IDLE, clear counter=0, read pipeline flushed. The array contents are not reset.
- FSM states: IDLE and CLEAR.
  - On the first edge after rstn release: go to CLEAR if INIT_ON_RESET=1, otherwise stay in IDLE.
  - IDLE -> CLEAR when clr_req=1 is sampled.
  - CLEAR writes 0 to address cnt each cycle, with cnt running 0..DEPTH-1. After writing DEPTH-1 it returns to IDLE.
- busy=1 exactly while the FSM is in CLEAR, so it is high for DEPTH cycles.
- clr_req while busy is ignored; the clear does not restart.
- Reset during CLEAR aborts the clear. After release the clear restarts from address 0 if INIT_ON_RESET=1.
- While busy=1, wr_en and rd_en are dropped silently: no write, no rd_valid, no error strobes.
- Write: accepted when wr_en=1, busy=0 and wr_addr<DEPTH. Only lanes with wr_be[i]=1 are updated at the edge. wr_be=0 is a legal no-op.
- Write out of range (wr_addr>=DEPTH): the array is unchanged and wr_err=1 for the following cycle.
- Read: a request sampled at edge E (rd_en=1, busy=0) drives rd_data, rd_valid=1 and rd_err after edge E+RD_LATENCY-1.
  - RD_LATENCY=1: valid in the cycle right after the request.
  - RD_LATENCY=2: one extra output register stage.
- Reads have full throughput: back-to-back reads every cycle, with no bubbles.
- rd_valid deasserts when there is no request. rd_data holds its last value when rd_valid=0.
- Read out of range: rd_data=0, rd_valid=1, rd_err=1.
- Collision (rd_en and wr_en to the same in-range address on the same edge):
  - READ_FIRST returns the pre-write word.
  - WRITE_FIRST returns the merged word: enabled lanes take wr_data, the other lanes keep the old data.
- Address width: when DEPTH is a power of two, no address is out of range.
- Elaboration error if DATA_W%8!=0 or RD_LATENCY is not in {1,2}.

Decomposition:
- Package ram_pkg holds:
  - the state typedef {IDLE, CLEAR};
  - the constants READ_FIRST=0 and WRITE_FIRST=1;
  - a byte-merge function (old, new, be) -> word.
- Sub-module ram_init_ctrl holds the FSM, the clear counter, busy, and the muxed write address/data/enable it drives into the array.
- The array, read pipeline and error logic stay in ram_sdp_be.

Test Plan:
1. Reset, INIT_ON_RESET=1, DEPTH=256 -> busy=1 for exactly 256 cycles after release. A read at addr 10 right after busy falls gives rd_data=0, rd_valid=1 one cycle later.
2. Write addr 10 data 32'h0000_00FF be=4'hF, then addr 10 data 32'hAABB_CCDD be=4'b1010, then read addr 10 -> rd_data=32'hAA00_CC00? No: expected 32'hAA00_CCFF.
3. Same-edge write addr 5 = 32'h1234_5678 (be=4'hF, prior content 0) and read addr 5 -> READ_FIRST gives 32'h0 and WRITE_FIRST gives 32'h1234_5678. Repeat with RD_LATENCY=2 and check rd_valid arrives 2 cycles after the request.
4. DEPTH=200: write addr 200 -> wr_err pulses for 1 cycle and addr 200 mod 256 aliasing is absent. Read addr 255 -> rd_data=0, rd_err=1, rd_valid=1.
5. Fill addresses 0..3 with 32'h1..32'h4, pulse clr_req, and issue wr_en/rd_en during busy -> no rd_valid and no error pulses. After busy falls, reads of 0..3 return 0.
6. Pull rstn low mid-clear (cycle 100) for 2 cycles -> outputs go to 0 immediately, and busy then runs a full 256 cycles after release. Back-to-back reads of addrs 1,2,3 on consecutive cycles -> three consecutive rd_valid cycles carrying the correct data.
